ram_1p_req_adapter: RTL and testbench

RAM_1P_REQ_ADAPTER -- requirements
Module: ram_1p_req_adapter

---
 rtl/ram_1p_adapter_pkg.sv | 21 ++
 rtl/ram_1p_rsp_fifo.sv | 49 ++++
 rtl/ram_1p_req_adapter.sv | 132 +++++++++++++
 tb/tb_ram_1p_req_adapter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_1p_adapter_pkg.sv
// Shared types and constants for the single-port RAM request adapter and its
// response FIFO. Response entries carry up to RspMaxWidth data bits.
package ram_1p_adapter_pkg;

    localparam int unsigned RspFifoDepth = 2;
    localparam int unsigned RspMaxWidth  = 128;
    localparam int unsigned CntW         = $clog2(RspFifoDepth + 1);
    localparam int unsigned PtrW         = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;

    typedef struct packed {
        logic                   write;
        logic [RspMaxWidth-1:0] rdata;
    } rsp_entry_t;

    localparam int unsigned RspEntryW = $bits(rsp_entry_t);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(RspFifoDepth - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/ram_1p_rsp_fifo.sv
// Two-entry response FIFO. Pushes while full and pops while empty are ignored;
// the credit scheme in the adapter keeps either from happening.
module ram_1p_rsp_fifo
    import ram_1p_adapter_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [RspEntryW-1:0] push_data_i,
    input  logic                 pop_i,
    output logic [RspEntryW-1:0] head_o,
    output logic                 full_o,
    output logic                 empty_o
);

    logic [RspEntryW-1:0] mem_q [RspFifoDepth];
    logic [PtrW-1:0]      wr_ptr_q;
    logic [PtrW-1:0]      rd_ptr_q;
    logic [CntW-1:0]      count_q;
    logic                 push_ok;
    logic                 pop_ok;

    assign full_o  = (count_q == CntW'(RspFifoDepth));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(RspFifoDepth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

endmodule

// File: rtl/ram_1p_req_adapter.sv
// Valid/ready front end for a single-port RAM with 1-cycle read latency and a
// credit-limited 2-entry response FIFO. Width must not exceed RspMaxWidth.
// Optional feature: RAM_1P_REQ_ADAPTER_WRITE_ACK_EN returns a response per write.
module ram_1p_req_adapter
    import ram_1p_adapter_pkg::*;
#(
    parameter int unsigned Width           = 32,
    parameter int unsigned Depth           = 128,
    parameter int unsigned DataBitsPerMask = 1,
    localparam int unsigned Aw             = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [Width-1:0] req_wmask_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             rsp_write_o,

    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i,

    input  logic [9:0]       cfg_i,
    output logic [9:0]       ram_cfg_o
);

    // Handshakes: a request transfers on a clock edge where req_valid_i and
    // req_ready_o are both high; a response transfers where rsp_valid_o and
    // rsp_ready_i are both high. req_ready_o depends on registers only.

    logic                 init_q;
    logic [CntW-1:0]      cnt_q;
    logic [CntW-1:0]      cnt_d;
    logic                 inflight_q;
    logic                 inflight_write_q;
    logic                 accept;
    logic                 take_credit;
    logic                 pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    rsp_entry_t           push_entry;
    rsp_entry_t           head_entry;
    logic [RspEntryW-1:0] head_bits;
    logic                 unused_sigs;

    assign req_ready_o = init_q & (cnt_q < CntW'(RspFifoDepth));
    assign accept      = req_valid_i & req_ready_o;

    assign ram_req_o   = accept;
    assign ram_write_o = req_write_i;
    assign ram_addr_o  = req_addr_i;
    assign ram_wdata_o = req_wdata_i;
    assign ram_wmask_o = req_wmask_i;
    assign ram_cfg_o   = cfg_i;

`ifdef RAM_1P_REQ_ADAPTER_WRITE_ACK_EN
    assign take_credit = accept;
`else
    assign take_credit = accept & ~req_write_i;
`endif

    assign pop = rsp_valid_o & rsp_ready_i;

    // A credit is held from acceptance until its response is popped.
    always_comb begin
        cnt_d = cnt_q;
        case ({take_credit, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q           <= 1'b0;
            cnt_q            <= '0;
            inflight_q       <= 1'b0;
            inflight_write_q <= 1'b0;
        end else begin
            init_q           <= 1'b1;
            cnt_q            <= cnt_d;
            inflight_q       <= take_credit;
            inflight_write_q <= take_credit & req_write_i;
        end
    end

    // RAM read data is valid in the cycle after the accepted request.
    always_comb begin
        push_entry       = '0;
        push_entry.write = inflight_write_q;
        if (!inflight_write_q) begin
            push_entry.rdata = RspMaxWidth'(ram_rdata_i);
        end
    end

    ram_1p_rsp_fifo u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (inflight_q),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .head_o      (head_bits),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign head_entry  = rsp_entry_t'(head_bits);
    assign rsp_valid_o = ~fifo_empty;
    assign rsp_rdata_o = rsp_valid_o ? head_entry.rdata[Width-1:0] : '0;

`ifdef RAM_1P_REQ_ADAPTER_WRITE_ACK_EN
    assign rsp_write_o = rsp_valid_o & head_entry.write;
`else
    assign rsp_write_o = 1'b0;
`endif

    // Mask granularity belongs to the RAM macro; the adapter forwards masks as-is.
    assign unused_sigs = ^{head_entry, fifo_full, 32'(DataBitsPerMask)};

endmodule

// File: tb/tb_ram_1p_req_adapter.sv
// Randomized scoreboard bench for ram_1p_req_adapter with a behavioural RAM
// and a reference memory/response-queue model.
`timescale 1ns/1ps
module tb_ram_1p_req_adapter;

  localparam int W  = 32;
  localparam int D  = 128;
  localparam int AW = $clog2(D);

`ifdef RAM_1P_REQ_ADAPTER_WRITE_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata, req_wmask;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [W-1:0]  rsp_rdata;
  logic          ram_req, ram_write;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_wdata, ram_wmask, ram_rdata;
  logic [9:0]    cfg, ram_cfg;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [W:0]  exp_q[$];
  logic [W-1:0] ram_mem [D];
  logic [W-1:0] ref_mem [D];
  bit          ready_chk_en = 1'b0;

  ram_1p_req_adapter #(.Width(W), .Depth(D), .DataBitsPerMask(1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_write_o(rsp_write),
    .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask), .ram_rdata_i(ram_rdata),
    .cfg_i(cfg), .ram_cfg_o(ram_cfg)
  );

  // clock
  always #5 clk = ~clk;

  // behavioural single-port RAM, one cycle read latency
  always @(posedge clk) begin
    if (ram_req) begin
      if (ram_write) ram_mem[ram_addr] <= (ram_mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
      else           ram_rdata <= ram_mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: applied at the moment a request is accepted
  task automatic model_accept(input logic w, input logic [AW-1:0] a,
                              input logic [W-1:0] d, input logic [W-1:0] m);
    if (w) begin
      ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
      if (ACK_EN) exp_q.push_back({1'b1, {W{1'b0}}});
    end else begin
      exp_q.push_back({1'b0, ref_mem[a]});
    end
  endtask

  // driver: enters and leaves at posedge+1; holds the request until accepted
  task automatic do_req(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                        input logic [W-1:0] m, input int unblock, output int waited);
    bit done;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
    waited = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      check("ram_fields", 128'({ram_write, ram_addr, ram_wdata, ram_wmask}), 128'({w, a, d, m}));
      check("ram_req", 128'(ram_req), 128'(req_ready));
      if (req_ready) begin
        model_accept(w, a, d, m);
        done = 1'b1;
      end else begin
        waited++;
        if (unblock != 0 && waited == unblock) rsp_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("req_timeout", 128'(0), 128'(1));
  endtask

  task automatic drain();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) break;
    end
    repeat (2) begin @(posedge clk); #1; end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  // scoreboard monitor: pops on every response handshake
  bit         hold_prev = 1'b0;
  logic [W:0] prev_head;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      check("fifo_overrun", 128'(dut.u_rsp_fifo.full_o & dut.inflight_q), 128'(0));
      if (hold_prev && rsp_valid) check("head_stable", 128'({rsp_write, rsp_rdata}), 128'(prev_head));
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 128'({rsp_write, rsp_rdata}), 128'(0) - 1);
        else check("rsp", 128'({rsp_write, rsp_rdata}), 128'(exp_q.pop_front()));
      end
      hold_prev = rsp_valid && !rsp_ready;
      prev_head = {rsp_write, rsp_rdata};
    end
  end

  // credit check: outstanding responses in the model bound req_ready
  always @(posedge clk) begin
    #2;
    if (rst_n && ready_chk_en) check("req_ready_credit", 128'(req_ready), 128'(exp_q.size() < 2));
  end

  initial begin
    int wt;
    logic [W-1:0] m;

    req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    rsp_ready = 1'b0; cfg = 10'h2A5;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_ram_req", 128'(ram_req), 128'(0));
    check("rst_rsp", 128'({rsp_valid, rsp_write, rsp_rdata}), 128'(0));
    check("cfg_pass", 128'(ram_cfg), 128'(10'h2A5));
    cfg = 10'h15A;
    #1 check("cfg_pass2", 128'(ram_cfg), 128'(10'h15A));
    req_valid = 1'b0;

    // reset release: ready low in first cycle, high from second
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("ready_cycle1", 128'(req_ready), 128'(0));
    check("rsp_valid_cycle1", 128'(rsp_valid), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_cycle2", 128'(req_ready), 128'(1));
    check("rsp_valid_cycle2", 128'(rsp_valid), 128'(0));
    @(posedge clk); #1;
    ready_chk_en = 1'b1;

    // prefill the address window used below
    rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++) do_req(1'b1, AW'(i), $urandom, '1, 0, wt);
    drain();

    // write then read addr 5: data and 2-cycle latency
    do_req(1'b1, AW'(5), 32'hDEADBEEF, '1, 0, wt);
    drain();
    do_req(1'b0, AW'(5), '0, '0, 0, wt);
    req_valid = 1'b0;
    @(negedge clk);
    check("rd_latency_c1", 128'(rsp_valid), 128'(0));
    @(posedge clk); #1;
    @(negedge clk);
    check("rd_latency_c2", 128'(rsp_valid), 128'(1));
    check("rd5_data", 128'(rsp_rdata), 128'(32'hDEADBEEF));
    @(posedge clk); #1;
    drain();

    // partial mask write; write acks (if enabled) precede the read data
    do_req(1'b1, AW'(9), 32'hFFFFFFFF, '1, 0, wt);
    do_req(1'b1, AW'(9), 32'h12345678, 32'h0000FFFF, 0, wt);
    do_req(1'b0, AW'(9), '0, '0, 0, wt);
    req_valid = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        if (rsp_valid && !rsp_write) begin
          check("mask_merge", 128'(rsp_rdata), 128'(32'hFFFF5678));
          seen = 1'b1;
        end
      end
      if (!seen) check("mask_merge_timeout", 128'(0), 128'(1));
      @(posedge clk); #1;
    end
    drain();

    // back-pressure: only two reads accepted while rsp_ready is low
    rsp_ready = 1'b0;
    do_req(1'b0, AW'(1), '0, '0, 0, wt);
    do_req(1'b0, AW'(2), '0, '0, 0, wt);
    req_valid = 1'b1; req_write = 1'b0; req_addr = AW'(3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ready_when_full", 128'(req_ready), 128'(0));
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    do_req(1'b0, AW'(3), '0, '0, 0, wt);
    drain();

    // one entry held, then continuous reads with continuous pops
    rsp_ready = 1'b0;
    do_req(1'b0, AW'(4), '0, '0, 0, wt);
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) do_req(1'b0, AW'($urandom_range(0, 15)), '0, '0, 0, wt);
    drain();

    // reset with two responses pending
    rsp_ready = 1'b0;
    do_req(1'b0, AW'(6), '0, '0, 0, wt);
    do_req(1'b0, AW'(7), '0, '0, 0, wt);
    req_valid = 1'b1; req_addr = AW'(8);
    repeat (2) begin @(posedge clk); #1; end
    ready_chk_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("midrst_req_ready", 128'(req_ready), 128'(0));
    check("midrst_ram_req", 128'(ram_req), 128'(0));
    check("midrst_rsp", 128'({rsp_valid, rsp_write, rsp_rdata}), 128'(0));
    exp_q.delete();
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1; ready_chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_rsp", 128'(rsp_valid), 128'(0));
      @(posedge clk); #1;
    end

    // random traffic
    for (int n = 0; n < 200; n++) begin
      rsp_ready = ($urandom_range(0, 3) != 0);
      m = ($urandom_range(0, 1) != 0) ? '1 : W'($urandom);
      do_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom, m, 3, wt);
      if ($urandom_range(0, 4) == 0) begin
        req_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
